instr_state_sequencer: RTL and testbench
========================================

Name: instr_state_sequencer

Overview:
Multi-cycle state sequencer that generates the 3-bit `state` code consumed by the enable-decoding Controller. It accepts one instruction opcode at a time from the fetch/decode path and steps through the execute, memory-wait and PC-update states. It also handles the data-memory ready handshake with a timeout, pipeline stall, and illegal-opcode reporting. It sits between instruction decode and Controller in the single-cycle/multi-cycle datapath.

Parameters:
MEM_TIMEOUT, 16, max cycles to wait for memReady in a memory state before aborting (>=1)
CNT_W, 5, width of timeout counter; must satisfy 2**CNT_W > MEM_TIMEOUT

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
instrValid  input  1  opcode valid from decode
opcode  input  7  instruction bits [6:0]
memReady  input  1  data memory has completed the current access
stall  input  1  freeze sequencer (hazard/debug)
instrAccept  output  1  1-cycle pulse: opcode captured
state  output  3  state code to Controller (`IDLE/`RegsWrite/`MemtoRegs/`MemWrite/`PCWrite)
instrDone  output  1  1-cycle pulse in the final cycle of PCWrite
illegalInstr  output  1  1-cycle pulse: unsupported opcode captured
memTimeout  output  1  1-cycle pulse: memory wait aborted

Behaviour:
- One clock; reset is synchronous and active-high. Port names clk and reset.
- Reset: state=`IDLE, latched opcode=0, counter=0, all pulse outputs 0. Reset asserted mid-instruction aborts it and emits no pulses.
- Registered FSM. `state` is the register. Pulses are registered, asserted in the cycle after the triggering edge condition.
- IDLE: when instrValid && !stall, latch opcode, assert instrAccept, and go to the class state:
  - OP 0110011, OP-IMM 0010011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111 -> RegsWrite
  - LOAD 0000011 -> MemtoRegs
  - STORE 0100011 -> MemWrite
  - BRANCH 1100011 -> PCWrite
  - any other value -> stays IDLE, illegalInstr pulses, instrAccept still pulses.
- RegsWrite: exactly 1 cycle, then PCWrite.
- MemtoRegs / MemWrite:
  - Counter clears on entry and increments each non-stalled cycle while memReady=0.
  - memReady=1 -> PCWrite next cycle.
  - Counter reaches MEM_TIMEOUT with memReady=0 -> PCWrite, memTimeout pulses.
  - memReady and the timeout in the same cycle: memReady wins, no memTimeout.
- PCWrite: 1 cycle, instrDone pulses, then IDLE. instrValid seen in PCWrite is ignored; it is accepted in IDLE only, so an instruction takes at least 3 cycles.
- stall=1: state, counter and latched opcode hold; no pulses generated; memReady arriving during stall is ignored (the memory must hold ready until the stall clears).
- Unused `state` encodings (5-7) recover to IDLE on the next clock.
- Latency, accept to instrDone: ALU/jump 3 cycles; branch 2; load/store 3+N, where N = cycles memReady is low.

Decomposition:
- State codes `IDLE=3'd0, `RegsWrite=3'd1, `MemtoRegs=3'd2, `MemWrite=3'd3, `PCWrite=3'd4, and the opcode constants, live in the shared Defines.v. Reuse them there; do not redefine locally.
- One sub-module is natural: opcode_classifier, a combinational opcode -> {next class state, illegal} map, reusable by decode.

Test Plan:
- OP 0110011 with instrValid in IDLE -> state sequence 0,1,4,0; instrAccept at cycle 1, instrDone at cycle 3.
- LOAD 0000011, memReady asserted after 3 cycles -> state 2 held 4 cycles, then 4, then 0; no memTimeout.
- STORE 0100011 with memReady held 0, MEM_TIMEOUT=16 -> state 3 for 16 cycles, memTimeout pulse, then 4, then 0.
- BRANCH 1100011 -> 0,4,0. Opcode 1111111 -> stays 0 with illegalInstr and instrAccept pulsed, no instrDone.
- stall=1 for 5 cycles in MemtoRegs with memReady=0 -> state and counter frozen; timeout fires 5 cycles later than without the stall.
- reset pulse during MemWrite -> state=0 next cycle, no pulses; a new instruction is then accepted normally.

Source files
------------

// File: rtl/instr_state_sequencer_pkg.sv
// Shared state codes and opcode constants for the instruction sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package instr_state_sequencer_pkg;

    // State codes consumed by the enable-decoding Controller
    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        REGS_WRITE  = 3'd1,
        MEM_TO_REGS = 3'd2,
        MEM_WRITE   = 3'd3,
        PC_WRITE    = 3'd4
    } seqStateT;

    // RV32 major opcodes (instruction bits [6:0])
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

endpackage

// File: rtl/instr_state_sequencer_opcode_classifier.sv
// Maps an opcode to the first sequencer state of its class, flags unsupported opcodes.
// Latency: combinational.
// Backpressure: none; pure function of the opcode.
module instr_state_sequencer_opcode_classifier
    import instr_state_sequencer_pkg::*;
(
    input  logic [6:0] opcode,
    output seqStateT   classState,
    output logic       illegal
);

    // Class lookup; unsupported opcodes leave the sequencer in IDLE
    always_comb begin
        classState = IDLE;
        illegal    = 1'b0;
        case (opcode)
            OPC_OP, OPC_OP_IMM, OPC_LUI,
            OPC_AUIPC, OPC_JAL, OPC_JALR: classState = REGS_WRITE;
            OPC_LOAD:                     classState = MEM_TO_REGS;
            OPC_STORE:                    classState = MEM_WRITE;
            OPC_BRANCH:                   classState = PC_WRITE;
            default:                      illegal    = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_state_sequencer.sv
// Multi-cycle state sequencer: accepts one opcode in IDLE and walks execute/memory/PC-update states.
// Latency: accept->instrDone is 3 (ALU/jump), 2 (branch), 3+N (load/store, N = memReady-low cycles).
// Backpressure: stall freezes everything; memory states wait for memReady up to MEM_TIMEOUT cycles.
module instr_state_sequencer
    import instr_state_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       instrValid,
    input  logic [6:0] opcode,
    input  logic       memReady,
    input  logic       stall,
    output logic       instrAccept,
    output logic [2:0] state,
    output logic       instrDone,
    output logic       illegalInstr,
    output logic       memTimeout
);

    // Counter value in the last allowed wait cycle; hitting it with memReady low aborts the access
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    seqStateT         stateQ;
    logic [CNT_W-1:0] memCnt;
    seqStateT         classState;
    logic             classIllegal;

    // The class state fully captures what the Controller needs from the opcode,
    // so the opcode itself is consumed at accept time and not held afterwards.
    instr_state_sequencer_opcode_classifier uClassifier (
        .opcode     (opcode),
        .classState (classState),
        .illegal    (classIllegal)
    );

    assign state = stateQ;

    // Sequencer FSM: state, wait counter and registered pulse outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ       <= IDLE;
            memCnt       <= '0;
            instrAccept  <= 1'b0;
            instrDone    <= 1'b0;
            illegalInstr <= 1'b0;
            memTimeout   <= 1'b0;
        end else begin
            instrAccept  <= 1'b0;
            instrDone    <= 1'b0;
            illegalInstr <= 1'b0;
            memTimeout   <= 1'b0;
            case (stateQ)
                IDLE: begin
                    if (!stall && instrValid) begin
                        instrAccept  <= 1'b1;
                        illegalInstr <= classIllegal;
                        stateQ       <= classState;
                        memCnt       <= '0;
                    end
                end
                REGS_WRITE: begin
                    if (!stall) begin
                        stateQ <= PC_WRITE;
                    end
                end
                MEM_TO_REGS, MEM_WRITE: begin
                    // memReady takes priority over a timeout landing in the same cycle
                    if (!stall) begin
                        if (memReady) begin
                            stateQ <= PC_WRITE;
                        end else if (memCnt == CNT_LAST) begin
                            stateQ     <= PC_WRITE;
                            memTimeout <= 1'b1;
                        end else begin
                            memCnt <= memCnt + CNT_W'(1);
                        end
                    end
                end
                PC_WRITE: begin
                    if (!stall) begin
                        instrDone <= 1'b1;
                        stateQ    <= IDLE;
                    end
                end
                // Encodings 5-7 are unreachable; recover regardless of stall
                default: stateQ <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_state_sequencer.sv
// Self-checking bench for instr_state_sequencer: directed cases plus random instruction streams.
// Latency: n/a.
// Backpressure: exercised via random and forced stall windows.
module tb_instr_state_sequencer;

    localparam int T = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       instrValid = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic       memReady = 1'b0;
    logic       stall = 1'b0;
    logic       instrAccept;
    logic [2:0] state;
    logic       instrDone;
    logic       illegalInstr;
    logic       memTimeout;

    int nChecks = 0;
    int nFails  = 0;

    logic [6:0] legalOps [9] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
                                 7'b1100111, 7'b0000011, 7'b0100011, 7'b1100011};

    instr_state_sequencer #(.MEM_TIMEOUT(T), .CNT_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .instrValid   (instrValid),
        .opcode       (opcode),
        .memReady     (memReady),
        .stall        (stall),
        .instrAccept  (instrAccept),
        .state        (state),
        .instrDone    (instrDone),
        .illegalInstr (illegalInstr),
        .memTimeout   (memTimeout)
    );

    always #5 clk = ~clk;

    // Class of an opcode as a state code: 0 illegal, 1 register write, 2 load, 3 store, 4 branch
    function automatic int refClass(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0010011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b1100111: return 1;
            7'b0000011:                         return 2;
            7'b0100011:                         return 3;
            7'b1100011:                         return 4;
            default:                            return 0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expOut(input string tag, input int st, input int acc, input int done,
                          input int ill, input int to);
        chk({tag, ".state"},        {29'd0, state},        st);
        chk({tag, ".instrAccept"},  {31'd0, instrAccept},  acc);
        chk({tag, ".instrDone"},    {31'd0, instrDone},    done);
        chk({tag, ".illegalInstr"}, {31'd0, illegalInstr}, ill);
        chk({tag, ".memTimeout"},   {31'd0, memTimeout},   to);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction and follow its expected state timeline.
    // lowCycles: non-stalled memory cycles with memReady low before it rises.
    // forceIdx/forceLen: insert forceLen stall cycles when the timeline reaches forceIdx.
    task automatic runInstr(input logic [6:0] op, input int lowCycles, input int stallPct,
                            input int forceIdx, input int forceLen, input string tag);
        int  phases[$];
        int  cls;
        int  n;
        int  idx;
        int  forced;
        int  expSt;
        bit  timeout;
        bit  st;
        bit  d;
        bit  to;
        cls     = refClass(op);
        timeout = 1'b0;
        case (cls)
            1: begin phases.push_back(1); phases.push_back(4); end
            4: phases.push_back(4);
            2, 3: begin
                if (lowCycles >= T) begin
                    n       = T;
                    timeout = 1'b1;
                end else begin
                    n = lowCycles + 1;
                end
                for (int i = 0; i < n; i++) phases.push_back(cls);
                phases.push_back(4);
            end
            default: ;
        endcase

        instrValid = 1'b1;
        opcode     = op;
        memReady   = 1'($urandom_range(0, 1));
        if (stallPct > 0) begin
            repeat ($urandom_range(0, 2)) begin
                stall = 1'b1;
                tick();
                expOut({tag, ".idleStall"}, 0, 0, 0, 0, 0);
            end
        end
        stall = 1'b0;
        tick();
        if (cls == 0) expOut({tag, ".illegal"}, 0, 1, 0, 1, 0);
        else          expOut({tag, ".accept"}, phases[0], 1, 0, 0, 0);

        idx    = 0;
        forced = 0;
        while (idx < phases.size()) begin
            if (idx == forceIdx && forced < forceLen) begin
                st = 1'b1;
                forced++;
            end else begin
                st = ($urandom_range(0, 99) < stallPct);
            end
            stall      = st;
            instrValid = 1'($urandom_range(0, 1));
            opcode     = 7'($urandom_range(0, 127));
            if (st || phases[idx] == 1 || phases[idx] == 4)
                memReady = 1'($urandom_range(0, 1));
            else
                memReady = (idx == phases.size() - 2) && !timeout;
            tick();
            if (st) begin
                expOut({tag, ".stall"}, phases[idx], 0, 0, 0, 0);
            end else begin
                d  = (phases[idx] == 4);
                to = timeout && (idx == phases.size() - 2);
                idx++;
                expSt = (idx < phases.size()) ? phases[idx] : 0;
                expOut({tag, ".step"}, expSt, 0, int'(d), 0, int'(to));
            end
        end
        instrValid = 1'b0;
        stall      = 1'b0;
        memReady   = 1'b0;
        tick();
        expOut({tag, ".idle"}, 0, 0, 0, 0, 0);
    endtask

    // Accept op, advance adv cycles with memReady low, then pulse reset
    task automatic resetMid(input logic [6:0] op, input int adv, input string tag);
        instrValid = 1'b1;
        opcode     = op;
        stall      = 1'b0;
        memReady   = 1'b0;
        tick();
        instrValid = 1'b0;
        repeat (adv) tick();
        reset = 1'b1;
        tick();
        expOut({tag, ".inReset"}, 0, 0, 0, 0, 0);
        reset = 1'b0;
        tick();
        expOut({tag, ".afterReset"}, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [6:0] op;
        repeat (3) tick();
        expOut("reset", 0, 0, 0, 0, 0);
        reset = 1'b0;
        tick();
        expOut("postReset", 0, 0, 0, 0, 0);

        runInstr(7'b0110011, 0,     0, -1, 0, "aluOp");
        runInstr(7'b0000011, 3,     0, -1, 0, "load3");
        runInstr(7'b0100011, 40,    0, -1, 0, "storeTimeout");
        runInstr(7'b0100011, T - 1, 0, -1, 0, "readyAtLimit");
        runInstr(7'b0000011, T,     0, -1, 0, "loadTimeout");
        runInstr(7'b1100011, 0,     0, -1, 0, "branch");
        runInstr(7'b1111111, 0,     0, -1, 0, "illegal");
        runInstr(7'b0000011, 40,    0,  2, 5, "loadStall5");
        runInstr(7'b0110011, 0,     0,  0, 3, "aluStall");
        resetMid(7'b0100011, 3, "rstMemWrite");
        runInstr(7'b0110111, 0,     0, -1, 0, "luiAfterReset");
        resetMid(7'b1100011, 0, "rstPcWrite");
        runInstr(7'b0000011, 2,     0, -1, 0, "loadAfterReset");

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0) op = 7'($urandom_range(0, 127));
            else                           op = legalOps[$urandom_range(0, 8)];
            runInstr(op, int'($urandom_range(0, 20)), 25, -1, 0, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
